// File: rtl/interp_mu_sequencer_if.sv
// rtl/interp_mu_sequencer_if.sv - upstream sample handshake between sample source and mu sequencer
interface interp_mu_sequencer_if;
   logic in_valid;
   logic in_ready;
   logic load_x;

   modport master (output in_valid, input in_ready, input load_x);
   modport slave  (input in_valid, output in_ready, output load_x);
endinterface

// File: rtl/interp_mu_sequencer.sv
// rtl/interp_mu_sequencer.sv - NCO phase/mu generator and delay-line shift control for the cubic Farrow interpolator
module interp_mu_sequencer #(
   parameter int DATA_WIDTH = 19,
   parameter int PH_W       = 16,
   parameter int TAPS       = 4,
   parameter int PIPE_LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [PH_W-1:0]       step,
   interp_mu_sequencer_if.slave  up,
   output logic [DATA_WIDTH-1:0] mu,
   output logic [PH_W-1:0]       mu_fx,
   output logic                  mu_valid,
   output logic                  out_valid,
   output logic                  busy,
   output logic [15:0]           stall_cnt
);

   localparam int FW = $clog2(TAPS + 1);
   localparam int IW = $clog2(PH_W);
   localparam int MW = DATA_WIDTH - 9;

   typedef enum logic [1:0] {IDLE, FILL, RUN, STALL} state_t;

   state_t              state, state_next;
   logic [PH_W-1:0]     phase, phase_next;
   logic [PH_W-1:0]     step_q, step_next;
   logic [FW-1:0]       fill_cnt, fill_next;
   logic [15:0]         stall_next;
   logic [PH_W:0]       sum;
   logic                carry;
   logic                ready;
   logic [PIPE_LAT-1:0] ov_pipe;

   // Normalise the Q0.PH_W phase so its MSB lands at the top, then take the bits below it as mantissa.
   function automatic logic [DATA_WIDTH-1:0] fx2fl(input logic [PH_W-1:0] p);
      logic [IW-1:0]   msb;
      logic [PH_W-1:0] norm;
      logic [7:0]      expo;
      msb = '0;
      for (int i = 0; i < PH_W; i++) begin
         if (p[i]) msb = IW'(i);
      end
      norm = p << (IW'(PH_W - 1) - msb);
      expo = 8'(127 - PH_W) + 8'(msb);
      if (p == '0) return '0;
      return {1'b0, expo, norm[PH_W-2 -: MW]};
   endfunction

   assign sum   = {1'b0, phase} + {1'b0, step_q};
   assign carry = sum[PH_W];

   always_comb begin
      state_next = state;
      phase_next = phase;
      step_next  = step_q;
      fill_next  = fill_cnt;
      stall_next = stall_cnt;
      ready      = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         phase_next = '0;
         fill_next  = '0;
      end else begin
         case (state)
            IDLE: begin
               state_next = FILL;
               phase_next = '0;
               step_next  = step;
               fill_next  = '0;
               stall_next = '0;
            end
            FILL: begin
               ready = 1'b1;
               if (up.in_valid) begin
                  if (fill_cnt == FW'(TAPS - 1)) begin
                     state_next = RUN;
                     phase_next = '0;
                     fill_next  = '0;
                  end else begin
                     fill_next = fill_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               // A carry means mu has wrapped past 1: the delay line must shift before mu can be used.
               ready = carry;
               if (!carry || up.in_valid) begin
                  phase_next = sum[PH_W-1:0];
               end else begin
                  state_next = STALL;
                  if (stall_cnt != 16'hFFFF) stall_next = stall_cnt + 1'b1;
               end
            end
            STALL: begin
               ready = 1'b1;
               if (up.in_valid) begin
                  phase_next = sum[PH_W-1:0];
                  state_next = RUN;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign up.in_ready = ready & rst_n;
   assign up.load_x   = up.in_valid & up.in_ready;
   assign busy        = (state != IDLE);
   assign out_valid   = ov_pipe[PIPE_LAT-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= '0;
         step_q    <= '0;
         fill_cnt  <= '0;
         stall_cnt <= '0;
         mu        <= '0;
         mu_fx     <= '0;
         mu_valid  <= 1'b0;
         ov_pipe   <= '0;
      end else begin
         state     <= state_next;
         phase     <= phase_next;
         step_q    <= step_next;
         fill_cnt  <= fill_next;
         stall_cnt <= stall_next;
         mu_fx     <= phase_next;
         mu        <= fx2fl(phase_next);
         mu_valid  <= (state_next == RUN);
         ov_pipe[0] <= mu_valid;
         for (int i = 1; i < PIPE_LAT; i++) ov_pipe[i] <= ov_pipe[i-1];
      end
   end

endmodule

// File: tb/tb_interp_mu_sequencer.sv
// tb/tb_interp_mu_sequencer.sv - randomized and directed bench for interp_mu_sequencer against a behavioural model
module tb_interp_mu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] step = '0;
   logic [18:0] mu;
   logic [15:0] mu_fx;
   logic        mu_valid, out_valid, busy;
   logic [15:0] stall_cnt;

   interp_mu_sequencer_if up ();

   interp_mu_sequencer #(.DATA_WIDTH(19), .PH_W(16), .TAPS(4), .PIPE_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .step(step), .up(up.slave),
      .mu(mu), .mu_fx(mu_fx), .mu_valid(mu_valid), .out_valid(out_valid),
      .busy(busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // mu as a real number in [0,1): value = 2^e * (1 + f), with e the power of two just below p.
   function automatic logic [18:0] float_ref(input int p);
      int e;
      int mant;
      if (p == 0) return 19'h0;
      e = 0;
      while ((1 << (e + 1)) <= p) e++;
      mant = ((p - (1 << e)) * 1024) >> e;
      return 19'((111 + e) * 1024 + mant);
   endfunction

   localparam int M_IDLE = 0, M_FILL = 1, M_RUN = 2, M_STALL = 3;
   int m_mode = M_IDLE, m_phase = 0, m_step = 0, m_fill = 0, m_stall = 0;
   bit m_mv = 0, m_h1 = 0, m_h2 = 0;

   always @(posedge clk) begin
      int s;
      if (!rst_n) begin
         m_mode = M_IDLE; m_phase = 0; m_step = 0; m_fill = 0; m_stall = 0;
         m_mv = 0; m_h1 = 0; m_h2 = 0;
      end else begin
         m_h2 = m_h1;
         m_h1 = m_mv;
         s = m_phase + m_step;
         if (!enable) begin
            m_mode = M_IDLE; m_phase = 0; m_fill = 0;
         end else if (m_mode == M_IDLE) begin
            m_mode = M_FILL; m_step = int'(step); m_stall = 0; m_fill = 0;
         end else if (m_mode == M_FILL) begin
            if (up.in_valid) begin
               m_fill++;
               if (m_fill == 4) begin m_mode = M_RUN; m_phase = 0; m_fill = 0; end
            end
         end else if (m_mode == M_RUN) begin
            if (s < 65536) m_phase = s;
            else if (up.in_valid) m_phase = s - 65536;
            else begin m_mode = M_STALL; if (m_stall < 65535) m_stall++; end
         end else if (up.in_valid) begin
            m_phase = s % 65536;
            m_mode = M_RUN;
         end
         m_mv = (m_mode == M_RUN);
      end
   end

   always @(negedge clk) begin
      logic er;
      er = rst_n && enable && (m_mode == M_FILL || m_mode == M_STALL ||
           (m_mode == M_RUN && m_phase + m_step >= 65536));
      chk("in_ready", up.in_ready, er);
      chk("load_x", up.load_x, er && up.in_valid);
      chk("mu_fx", mu_fx, m_phase);
      chk("mu", mu, float_ref(m_phase));
      chk("mu_valid", mu_valid, m_mv);
      chk("out_valid", out_valid, m_h2);
      chk("busy", busy, m_mode != M_IDLE);
      chk("stall_cnt", stall_cnt, m_stall);
   end

   task automatic step1;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [18:0] seq [8];
      logic [18:0] tab4 [4];
      int loads, n, nl, last, bad, ld;
      int held;
      bit found;
      tab4[0] = 19'h00000; tab4[1] = 19'h1F400; tab4[2] = 19'h1F800; tab4[3] = 19'h1FA00;
      up.in_valid = 1'b0;

      // reset and prime with step 0x4000
      repeat (3) step1;
      @(negedge clk);
      chk("rst_mu", mu, 0); chk("rst_busy", busy, 0); chk("rst_mu_valid", mu_valid, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      step1;
      rst_n = 1; enable = 1; step = 16'h4000; up.in_valid = 1;
      loads = 0; n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         @(negedge clk);
         if (up.load_x && !mu_valid) loads++;
         if (mu_valid) begin
            seq[n] = mu;
            if (up.load_x) chk("q_load_at_top", mu, 19'h1FA00);
            n++;
         end
         step1;
      end
      chk("prime_accepts", loads, 4);
      chk("q_mu_count", n, 8);
      for (int i = 0; i < 8; i++) chk("q_mu_seq", seq[i], tab4[i % 4]);

      // half rate
      enable = 0; step1;
      enable = 1; step = 16'h8000;
      n = 0; ld = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clk);
         if (mu_valid) begin
            seq[n] = mu;
            if (up.load_x) begin ld++; chk("h_load_at_half", mu, 19'h1F800); end
            n++;
         end
         step1;
      end
      chk("h_mu_count", n, 6);
      chk("h_loads", ld, 3);
      for (int i = 0; i < 6; i++) chk("h_mu_seq", seq[i], (i % 2) ? 19'h1F800 : 19'h0);

      // non-integer ratio 0x1C72
      enable = 0; step1;
      enable = 1; step = 16'h1C72;
      nl = 0; last = 0; bad = 0;
      for (int c = 0; c < 1500 && nl < 101; c++) begin
         @(negedge clk);
         if (nl == 1 && c == last + 1) chk("n_wrap1_mu_fx", mu_fx, 16'h0002);
         if (up.load_x && mu_valid) begin
            if (nl > 0 && c - last != 9) bad++;
            last = c;
            nl++;
         end
         step1;
      end
      chk("n_loads", nl, 101);
      chk("n_spacing_bad", bad, 0);

      // starvation at a carry cycle
      found = 0; held = 0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         if (mu_valid && int'(mu_fx) + 2 * 16'h1C72 >= 65536 && int'(mu_fx) + 16'h1C72 < 65536) begin
            found = 1;
            held = int'(mu_fx) + 16'h1C72;
         end
         step1;
      end
      chk("s_found", found, 1);
      up.in_valid = 0;
      @(negedge clk);
      chk("s_carry_ready", up.in_ready, 1);
      chk("s_carry_noload", up.load_x, 0);
      step1;
      @(negedge clk);
      chk("s_mu_valid", mu_valid, 0);
      chk("s_stall_cnt", stall_cnt, 1);
      chk("s_held", mu_fx, held);
      step1; step1;
      up.in_valid = 1;
      @(negedge clk);
      chk("s_accept", up.load_x, 1);
      step1;
      @(negedge clk);
      chk("s_resume_valid", mu_valid, 1);
      chk("s_resume_fx", mu_fx, (held + 16'h1C72) % 65536);
      step1;

      // disable mid-run, then re-prime
      enable = 0;
      @(negedge clk);
      chk("d_ready_low", up.in_ready, 0);
      step1;
      @(negedge clk);
      chk("d_busy", busy, 0); chk("d_mu_valid", mu_valid, 0);
      step1;
      enable = 1; step = 16'h4000;
      loads = 0; found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (mu_valid) found = 1;
         else begin
            if (up.load_x) loads++;
            step1;
         end
      end
      chk("d_reprime_accepts", loads, 4);
      chk("d_stall_cleared", stall_cnt, 0);
      step1;

      // reset during STALL
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (mu_valid && mu == 19'h1F800) found = 1;
         step1;
      end
      chk("r_found", found, 1);
      up.in_valid = 0;
      step1;
      @(negedge clk);
      chk("r_in_stall", stall_cnt, 1);
      step1;
      rst_n = 0; up.in_valid = 1;
      @(negedge clk);
      chk("r_no_load", up.load_x, 0);
      step1;
      @(negedge clk);
      chk("r_mu", mu, 0); chk("r_mu_fx", mu_fx, 0); chk("r_busy", busy, 0);
      chk("r_stall_cnt", stall_cnt, 0); chk("r_out_valid", out_valid, 0);
      step1;
      rst_n = 1;

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         up.in_valid = ($urandom_range(0, 99) < 80);
         enable = ($urandom_range(0, 199) != 0);
         rst_n = ($urandom_range(0, 499) != 0);
         step = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         step1;
      end
      rst_n = 1;
      step1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
